// File: rtl/outport_sched_if.sv
// ----------------------------------------------------------------------------
// outport_sched_if
// Bundles the per-output-port scheduler signals of the 5x5 router crossbar.
//   Towards the scheduler:
//     in_vld  [4:0]   head-of-FIFO valid, one bit per input port
//     in_dst  [14:0]  3-bit destination per input, [3i+2:3i]
//     in_tail [4:0]   head flit of input i is a packet tail
//     cred_in         one downstream credit returned this cycle
//   From the scheduler:
//     sel     [4:0]   registered one-hot crossbar select
//     pop     [4:0]   one-hot dequeue strobe to the input FIFOs
//     out_vld         flit on the crossbar output this cycle
//     credits         current downstream credit count
//     busy            wormhole lock held
//     cred_err        sticky credit overflow flag
//     wdog_to         one-cycle watchdog release pulse
// Modports: master = flit source / credit return side, slave = scheduler.
// ----------------------------------------------------------------------------
interface outport_sched_if #(
    parameter int CRDW = 3
);
    logic [4:0]      in_vld;
    logic [14:0]     in_dst;
    logic [4:0]      in_tail;
    logic            cred_in;
    logic [4:0]      sel;
    logic [4:0]      pop;
    logic            out_vld;
    logic [CRDW-1:0] credits;
    logic            busy;
    logic            cred_err;
    logic            wdog_to;

    modport master (
        output in_vld, in_dst, in_tail, cred_in,
        input  sel, pop, out_vld, credits, busy, cred_err, wdog_to
    );

    modport slave (
        input  in_vld, in_dst, in_tail, cred_in,
        output sel, pop, out_vld, credits, busy, cred_err, wdog_to
    );
endinterface

// File: rtl/outport_sched.sv
// ----------------------------------------------------------------------------
// outport_sched
// Per-output-port scheduler for the 5x5 router crossbar. Round-robin
// arbitration among the five input heads, wormhole lock held from head to
// tail, every flit gated on downstream credits.
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : outport_sched_if.slave (requests, credits in; select, pops,
//          credit count and status out)
// Parameters: PORTID (served output), CRED_MAX (downstream depth),
//             CRDW (credit counter width), WDOG_LIM (watchdog limit).
// Optional feature: define OUTSCHED_WDOG_EN to build the idle-lock watchdog;
// without it the lock is held indefinitely and wdog_to stays 0.
// ----------------------------------------------------------------------------
module outport_sched #(
    parameter int PORTID   = 0,
    parameter int CRED_MAX = 4,
    parameter int CRDW     = 3,
    parameter int WDOG_LIM = 16
) (
    input  logic             clk,
    input  logic             rst,
    outport_sched_if.slave   bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0]      PID  = 3'(PORTID);
    localparam logic [CRDW-1:0] CMAX = CRDW'(CRED_MAX);

    state_t          state_q, state_d;
    logic [4:0]      sel_q, sel_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [CRDW-1:0] cred_q, cred_d;
    logic            cerr_q, cerr_d;
    logic            wto_q, wto_d;

    logic [4:0]      req;
    logic [2:0]      owner;
    logic            xfer;
    logic            tail_x;
    logic            wdog_fire;

    function automatic logic [2:0] inc5(input logic [2:0] v);
        return (v == 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

    function automatic logic [2:0] oh2idx(input logic [4:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // First set request at or after the pointer, wrapping modulo 5.
    function automatic logic [4:0] rr_pick(input logic [4:0] r, input logic [2:0] p);
        logic [4:0] g;
        logic [2:0] idx;
        g   = '0;
        idx = p;
        for (int k = 0; k < 5; k++) begin
            if ((g == 5'd0) && r[idx]) g[idx] = 1'b1;
            idx = inc5(idx);
        end
        return g;
    endfunction

    always_comb begin
        req = '0;
        for (int i = 0; i < 5; i++) begin
            req[i] = bus.in_vld[i] && (bus.in_dst[3*i +: 3] == PID);
        end
    end

    assign owner  = oh2idx(sel_q);
    assign xfer   = (state_q == BUSY) && ((bus.in_vld & sel_q) != 5'd0) && (cred_q != '0);
    assign tail_x = (bus.in_tail & sel_q) != 5'd0;

`ifdef OUTSCHED_WDOG_EN
    localparam int WDW = $clog2(WDOG_LIM + 1);

    logic [WDW-1:0] wcnt_q, wcnt_d;

    // Counts consecutive BUSY cycles without a transfer; the cycle that
    // would reach WDOG_LIM releases the lock instead.
    always_comb begin
        wcnt_d    = '0;
        wdog_fire = 1'b0;
        if (state_q == BUSY && !xfer) begin
            if (wcnt_q == WDW'(WDOG_LIM - 1)) begin
                wdog_fire = 1'b1;
            end else begin
                wcnt_d = wcnt_q + WDW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wcnt_q <= '0;
        else     wcnt_q <= wcnt_d;
    end
`else
    // WDOG_LIM only matters when the watchdog is built in; this is constant 0.
    assign wdog_fire = (WDOG_LIM < 0);
`endif

    // Lock FSM: IDLE arbitrates, BUSY holds the owner until tail or watchdog.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        wto_d   = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = rr_pick(req, ptr_q);
                if (sel_d != 5'd0) state_d = BUSY;
            end
            BUSY: begin
                if ((xfer && tail_x) || wdog_fire) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    ptr_d   = inc5(owner);
                    wto_d   = wdog_fire;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase
    end

    // Credit counter: a transfer and a return in the same cycle cancel out.
    always_comb begin
        cred_d = cred_q;
        cerr_d = cerr_q;
        case ({xfer, bus.cred_in})
            2'b10: cred_d = cred_q - CRDW'(1);
            2'b01: begin
                if (cred_q == CMAX) cerr_d = 1'b1;
                else                cred_d = cred_q + CRDW'(1);
            end
            default: cred_d = cred_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cred_q  <= CMAX;
            cerr_q  <= 1'b0;
            wto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cred_q  <= cred_d;
            cerr_q  <= cerr_d;
            wto_q   <= wto_d;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.pop      = xfer ? sel_q : 5'd0;
    assign bus.out_vld  = xfer;
    assign bus.credits  = cred_q;
    assign bus.busy     = (state_q == BUSY);
    assign bus.cred_err = cerr_q;
    assign bus.wdog_to  = wto_q;

endmodule

// File: tb/tb_outport_sched.sv
// ----------------------------------------------------------------------------
// tb_outport_sched
// Directed bench for outport_sched (PORTID=0, CRED_MAX=4, CRDW=3,
// WDOG_LIM=16). Inputs change just after the falling edge; outputs are
// sampled 1 time unit later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_outport_sched;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   pops;

    outport_sched_if #(.CRDW(3)) bus ();

    outport_sched #(
        .PORTID  (0),
        .CRED_MAX(4),
        .CRDW    (3),
        .WDOG_LIM(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic [4:0] v, input logic [14:0] d,
                       input logic [4:0] t, input logic c);
        bus.in_vld  = v;
        bus.in_dst  = d;
        bus.in_tail = t;
        bus.cred_in = c;
        #1;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.in_vld  = '0;
        bus.in_dst  = '0;
        bus.in_tail = '0;
        bus.cred_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [4:0] RR_SEL [8] = '{5'd0, 5'd1, 5'd0, 5'd4, 5'd0, 5'd16, 5'd0, 5'd1};

    localparam logic [4:0]  WH_VLD  [6] = '{5'b01010, 5'b01010, 5'b01010, 5'b01010, 5'b01000, 5'b01000};
    localparam logic [14:0] WH_DST  [6] = '{15'h0, 15'h0, 15'h0028, 15'h0, 15'h0, 15'h0};
    localparam logic [4:0]  WH_TAIL [6] = '{5'b01000, 5'b01000, 5'b01000, 5'b01010, 5'b01000, 5'b01000};
    localparam logic        WH_CRED [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [4:0]  WH_SEL  [6] = '{5'b00000, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b01000};

    localparam logic [4:0] CS_POP  [10] = '{5'd0, 5'd4, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0};
    localparam logic [2:0] CS_CRED [10] = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};

    initial begin
        n_vec = 0;
        n_err = 0;
        pops  = 0;
        rst   = 1'b1;

        // Reset state
        drv(5'd0, 15'd0, 5'd0, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_credits",  32'(bus.credits),  32'd4);
        chk("rst_sel",      32'(bus.sel),      32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_pop",      32'(bus.pop),      32'd0);
        chk("rst_cred_err", 32'(bus.cred_err), 32'd0);
        chk("rst_wdog_to",  32'(bus.wdog_to),  32'd0);
        nxt();
        rst = 1'b0;
        drv(5'd0, 15'd0, 5'd0, 1'b0);
        chk("t1_idle0_sel", 32'(bus.sel), 32'd0);
        nxt();
        drv(5'd0, 15'd0, 5'd0, 1'b0);
        nxt();
        // in0 for port 0, in3 destined elsewhere (dst=2) must be ignored
        drv(5'b01001, 15'h0400, 5'b01001, 1'b0);
        chk("t1_req_sel", 32'(bus.sel), 32'd0);
        chk("t1_req_pop", 32'(bus.pop), 32'd0);
        nxt();
        drv(5'b01001, 15'h0400, 5'b01001, 1'b0);
        chk("t1_grant_sel",  32'(bus.sel),     32'b00001);
        chk("t1_grant_pop",  32'(bus.pop),     32'b00001);
        chk("t1_grant_ovld", 32'(bus.out_vld), 32'd1);
        chk("t1_grant_busy", 32'(bus.busy),    32'd1);
        nxt();
        drv(5'b01000, 15'h0400, 5'b01000, 1'b1);
        chk("t1_after_sel",  32'(bus.sel),     32'd0);
        chk("t1_after_busy", 32'(bus.busy),    32'd0);
        chk("t1_after_cred", 32'(bus.credits), 32'd3);
        nxt();
        drv(5'b01000, 15'h0400, 5'b01000, 1'b0);
        chk("t1_foreign_sel", 32'(bus.sel),      32'd0);
        chk("t1_ret_cred",    32'(bus.credits),  32'd4);
        chk("t1_cred_err",    32'(bus.cred_err), 32'd0);
        nxt();

        // Round-robin among in0, in2, in4
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drv(5'b10101, 15'd0, 5'b10101, 1'((c % 2) == 1));
            chk($sformatf("rr_sel%0d", c), 32'(bus.sel), 32'(RR_SEL[c]));
            chk($sformatf("rr_pop%0d", c), 32'(bus.pop), 32'(RR_SEL[c]));
            nxt();
        end
        drv(5'd0, 15'd0, 5'd0, 1'b0);
        chk("rr_credits",  32'(bus.credits),  32'd4);
        chk("rr_cred_err", 32'(bus.cred_err), 32'd0);
        nxt();

        // Wormhole lock: in1 3-flit packet, in3 waiting
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drv(WH_VLD[c], WH_DST[c], WH_TAIL[c], WH_CRED[c]);
            chk($sformatf("wh_sel%0d", c),  32'(bus.sel),  32'(WH_SEL[c]));
            chk($sformatf("wh_pop%0d", c),  32'(bus.pop),  32'(WH_SEL[c]));
            chk($sformatf("wh_busy%0d", c), 32'(bus.busy), 32'(WH_SEL[c] != 5'd0));
            nxt();
        end
        drv(5'd0, 15'd0, 5'd0, 1'b0);
        chk("wh_end_sel",  32'(bus.sel),     32'd0);
        chk("wh_end_cred", 32'(bus.credits), 32'd4);
        nxt();

        // Credit stall: 6-flit packet from in2, one credit returned late
        do_reset();
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            drv(5'b00100, 15'd0, 5'd0, 1'(c == 7));
            chk($sformatf("cs_pop%0d", c),  32'(bus.pop),     32'(CS_POP[c]));
            chk($sformatf("cs_cred%0d", c), 32'(bus.credits), 32'(CS_CRED[c]));
            if (c > 0) chk($sformatf("cs_sel%0d", c), 32'(bus.sel), 32'b00100);
            if (bus.out_vld) pops++;
            nxt();
        end
        drv(5'b00100, 15'd0, 5'd0, 1'b0);
        chk("cs_total_pops", 32'(pops),      32'd5);
        chk("cs_busy",       32'(bus.busy),  32'd1);
        nxt();

        // Simultaneous xfer+credit, then overflow, then lock held without vld
        do_reset();
        drv(5'b00100, 15'd0, 5'd0, 1'b0);
        nxt();
        drv(5'b00100, 15'd0, 5'd0, 1'b0);
        chk("ov_c1_cred", 32'(bus.credits), 32'd4);
        nxt();
        drv(5'b00100, 15'd0, 5'd0, 1'b0);
        chk("ov_c2_cred", 32'(bus.credits), 32'd3);
        nxt();
        drv(5'b00100, 15'd0, 5'd0, 1'b1);
        chk("ov_c3_cred", 32'(bus.credits), 32'd2);
        chk("ov_c3_pop",  32'(bus.pop),     32'b00100);
        nxt();
        drv(5'd0, 15'd0, 5'd0, 1'b1);
        chk("ov_simul_cred", 32'(bus.credits), 32'd2);
        chk("ov_c4_pop",     32'(bus.pop),     32'd0);
        nxt();
        drv(5'd0, 15'd0, 5'd0, 1'b1);
        chk("ov_c5_cred", 32'(bus.credits), 32'd3);
        nxt();
        drv(5'd0, 15'd0, 5'd0, 1'b1);
        chk("ov_c6_cred", 32'(bus.credits),  32'd4);
        chk("ov_c6_err",  32'(bus.cred_err), 32'd0);
        nxt();
        drv(5'd0, 15'd0, 5'd0, 1'b0);
        chk("ov_sat_cred", 32'(bus.credits),  32'd4);
        chk("ov_sat_err",  32'(bus.cred_err), 32'd1);
        chk("ov_lock_busy", 32'(bus.busy),    32'd1);
        chk("ov_lock_sel",  32'(bus.sel),     32'b00100);
        chk("ov_lock_pop",  32'(bus.pop),     32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_sel",  32'(bus.sel),      32'd0);
        chk("mid_rst_busy", 32'(bus.busy),     32'd0);
        chk("mid_rst_cred", 32'(bus.credits),  32'd4);
        chk("mid_rst_err",  32'(bus.cred_err), 32'd0);
        nxt();
        rst = 1'b0;

        // Owner stalls after its head flit; in3 waiting
        do_reset();
        drv(5'b01010, 15'd0, 5'b01000, 1'b0);
        nxt();
        drv(5'b01010, 15'd0, 5'b01000, 1'b1);
        chk("wd_head_pop", 32'(bus.pop), 32'b00010);
        nxt();
        for (int c = 2; c < 18; c++) begin
            drv(5'b01000, 15'd0, 5'b01000, 1'b0);
            chk($sformatf("wd_hold%0d", c), 32'({bus.busy, bus.wdog_to, bus.sel, bus.pop}),
                32'({1'b1, 1'b0, 5'b00010, 5'b00000}));
            nxt();
        end
        drv(5'b01000, 15'd0, 5'b01000, 1'b1);
`ifdef OUTSCHED_WDOG_EN
        chk("wd_release_busy", 32'(bus.busy),    32'd0);
        chk("wd_release_to",   32'(bus.wdog_to), 32'd1);
        chk("wd_release_sel",  32'(bus.sel),     32'd0);
        nxt();
        drv(5'b01000, 15'd0, 5'b01000, 1'b1);
        chk("wd_next_sel", 32'(bus.sel),     32'b01000);
        chk("wd_next_pop", 32'(bus.pop),     32'b01000);
        chk("wd_next_to",  32'(bus.wdog_to), 32'd0);
`else
        chk("nowd_hold_busy", 32'(bus.busy),    32'd1);
        chk("nowd_hold_to",   32'(bus.wdog_to), 32'd0);
        chk("nowd_hold_sel",  32'(bus.sel),     32'b00010);
`endif
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
